// File: rtl/gates_pkg.sv
// Shared types and the two-input gate primitive for the gates pipeline.
// gate2 is the single definition of each base op, used per bit.
package gates_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_BUF = 2'b11
    } op_e;

    localparam int OP_INV_BIT = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } pkt_st_e;

    typedef struct packed {
        logic       valid;
        logic       acc;
        logic       last;
        logic [2:0] op;
    } s1_ctl_t;

    // BUF keeps the left operand, so folds keep the first value seen.
    function automatic logic gate2(
        input op_e  op,
        input logic a,
        input logic b
    );
        logic r;
        r = a;
        unique case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_BUF: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gates_pipe_if.sv
// Valid/ready stream bundle between producer, gates_pipe and consumer.
// The slave side is the gates unit itself.
interface gates_pipe_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4
);

    logic [N_IN*WIDTH-1:0] in_data;
    logic [2:0]            in_op;
    logic                  in_acc;
    logic                  in_last;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_y;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data,
        output in_op,
        output in_acc,
        output in_last,
        output in_valid,
        input  in_ready,
        input  out_y,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_data,
        input  in_op,
        input  in_acc,
        input  in_last,
        input  in_valid,
        output in_ready,
        output out_y,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/gates_reduce.sv
// Combinational bitwise fold of N_IN operands with one base op.
// Operand 0 is the seed, so BUF yields operand 0 unchanged.
module gates_reduce
    import gates_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4
) (
    input  logic [N_IN*WIDTH-1:0] data,
    input  op_e                   op,
    output logic [WIDTH-1:0]      y
);

    always_comb begin
        logic [WIDTH-1:0] r;
        r = data[WIDTH-1:0];
        for (int k = 1; k < N_IN; k++) begin
            for (int b = 0; b < WIDTH; b++) begin
                r[b] = gate2(op, r[b], data[k*WIDTH+b]);
            end
        end
        y = r;
    end

endmodule

// File: rtl/gates_pipe.sv
// Two-stage multi-input gate unit with packet accumulation.
// S1 registers the beat; S2 reduces, folds and drives the output.
module gates_pipe
    import gates_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4
) (
    input logic         clk,
    input logic         rst,
    gates_pipe_if.slave bus
);

    logic                  en;
    s1_ctl_t               s1_q;
    logic [N_IN*WIDTH-1:0] s1_data_q;

    pkt_st_e          st_q, st_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [2:0]       pkt_op_q, pkt_op_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             vld_q, vld_d;

    op_e              red_op;
    logic [WIDTH-1:0] red;
    logic [WIDTH-1:0] fold;

    logic is_single;
    logic is_first;
    logic is_mid;
    logic is_end;

    assign en            = !vld_q || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_y     = y_q;
    assign bus.out_valid = vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            s1_data_q <= '0;
        end else if (en) begin
            s1_q <= '{
                valid: bus.in_valid,
                acc:   bus.in_acc,
                last:  bus.in_last,
                op:    bus.in_op
            };
            s1_data_q <= bus.in_data;
        end
    end

    // Continuation beats reduce with the op latched at packet start.
    assign red_op = (s1_q.acc && st_q == ST_PKT)
                  ? op_e'(pkt_op_q[1:0])
                  : op_e'(s1_q.op[1:0]);

    gates_reduce #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_reduce (
        .data (s1_data_q),
        .op   (red_op),
        .y    (red)
    );

    always_comb begin
        fold = acc_q;
        for (int b = 0; b < WIDTH; b++) begin
            fold[b] = gate2(op_e'(pkt_op_q[1:0]), acc_q[b], red[b]);
        end
    end

    // An acc=0 beat always wins, which also aborts any open packet.
    assign is_single = s1_q.valid
                    && (!s1_q.acc
                    || (st_q == ST_IDLE && s1_q.last));
    assign is_first  = s1_q.valid && s1_q.acc
                    && st_q == ST_IDLE && !s1_q.last;
    assign is_mid    = s1_q.valid && s1_q.acc
                    && st_q == ST_PKT && !s1_q.last;
    assign is_end    = s1_q.valid && s1_q.acc
                    && st_q == ST_PKT && s1_q.last;

    always_comb begin
        st_d     = st_q;
        acc_d    = acc_q;
        pkt_op_d = pkt_op_q;
        y_d      = y_q;
        vld_d    = vld_q;
        if (en) begin
            vld_d = 1'b0;
            unique case (1'b1)
                is_single: begin
                    y_d   = red ^ {WIDTH{s1_q.op[OP_INV_BIT]}};
                    vld_d = 1'b1;
                    st_d  = ST_IDLE;
                    acc_d = '0;
                end
                is_first: begin
                    acc_d    = red;
                    pkt_op_d = s1_q.op;
                    st_d     = ST_PKT;
                end
                is_mid: begin
                    acc_d = fold;
                end
                is_end: begin
                    y_d   = fold ^ {WIDTH{pkt_op_q[OP_INV_BIT]}};
                    vld_d = 1'b1;
                    st_d  = ST_IDLE;
                    acc_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q     <= ST_IDLE;
            acc_q    <= '0;
            pkt_op_q <= '0;
            y_q      <= '0;
            vld_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            acc_q    <= acc_d;
            pkt_op_q <= pkt_op_d;
            y_q      <= y_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: doc/gates_pipe.md
# gates_pipe

Parametrised, pipelined multi-input logic gate unit, the registered successor to the basic combinational gates. It reduces `N_IN` operands of `WIDTH` bits with a run-time selectable operation: AND, OR, XOR or BUF, each optionally inverted. A packet mode folds the result across several beats. It sits between producer/consumer blocks on a valid/ready stream.

## Interface
Parameters:
- `WIDTH`, 8, bit width of each operand and of the result (≥1).
- `N_IN`, 4, number of operands per beat (≥2).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  N_IN*WIDTH  operands; operand k = `in_data[k*WIDTH +: WIDTH]`.
- `in_op`  in  3  `[1:0]` base op: 00 AND, 01 OR, 10 XOR, 11 BUF (operand 0); `[2]` invert result.
- `in_acc`  in  1  1 = beat belongs to a multi-beat packet (accumulate mode).
- `in_last`  in  1  last beat of packet; ignored when `in_acc`=0.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  unit accepts beat this cycle.
- `out_y`  out  WIDTH  result.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.

## Operation
- Transfer occurs on a cycle with valid&&ready high, on either side.
- Stage 1 (S1) registers operands, op, acc, last and valid.
- Stage 2 (S2) computes the bitwise reduction of the S1 operands with the base op:
  - AND/OR/XOR: fold over all N_IN operands.
  - BUF: operand 0.
- Single-beat (`acc`=0): `out_y` = reduction, inverted if op[2]. `out_valid` set.
- Accumulate mode. S2 holds accumulator `acc_q` (WIDTH) and flag `in_pkt`.
  - First beat (`in_pkt`=0): latch op into `pkt_op`. Seed: `acc_q` = reduction. Set `in_pkt`.
  - Subsequent beats: `acc_q` = base_op(`acc_q`, reduction), using `pkt_op`. `in_op` on these beats is ignored.
  - For BUF packets, subsequent beats leave `acc_q` unchanged, so the result is the first beat's operand 0.
  - Non-last beats produce no output (`out_valid` stays 0).
  - Last beat: `out_y` = final fold, inverted if `pkt_op[2]`. `out_valid`=1; clear `in_pkt`.
  - Single-beat packet (`acc`=1, `last`=1 on first beat): identical to `acc`=0.
- Inversion is applied only to the final result, never to intermediate `acc_q`. NAND-packet = ~(AND of all beats).
- `acc`=0 beat arriving while `in_pkt`=1: the open packet is aborted (`acc_q` and `in_pkt` cleared). The beat is then processed as single-beat.
- Reset: S1/S2 valids=0, `out_valid`=0, `out_y`=0, `acc_q`=0, `in_pkt`=0, `pkt_op`=0.
- Reset mid-packet discards the partial accumulation; no output is produced for it.

## Timing
- Global enable `en` = !`out_valid` || `out_ready`. Both stages advance only when `en`=1.
- `in_ready` = `en` (combinational from `out_valid`/`out_ready`; no path from `in_valid`).
- Latency: a beat accepted at edge n appears on `out_y` with `out_valid` after edge n+2, provided `out_ready` stays high.
- Throughput: one beat/cycle with no backpressure.
- Backpressure: while `out_valid`=1 and `out_ready`=0:
  - `out_y` and `out_valid` hold stable.
  - `in_ready`=0.
  - S1 contents hold.
- A bubble (S1 invalid) advancing into S2 clears `out_valid` when `en`=1.
- Non-last accumulate beats advancing into S2 also clear `out_valid` when `en`=1.
- `rst` has priority over `en` and all transfers.

## Structure
- Shared package `gates_pkg`:
  - op encodings `OP_AND`=2'b00, `OP_OR`=2'b01, `OP_XOR`=2'b10, `OP_BUF`=2'b11.
  - `OP_INV_BIT`=2.
  - function `gate2(op, a, b)` used by both the reduction and the accumulator.
- One sub-module `gates_reduce`: combinational N_IN×WIDTH reduction tree, parameterised on `WIDTH`/`N_IN`.
- The top module holds the pipeline registers, accumulator and handshake.

## Test plan
- Single-beat ops, WIDTH=8, N_IN=4, operands {0x0F,0x3C,0xF0,0xFF}, `out_ready`=1:
  - AND→0x00, OR→0xFF, XOR→0x3C, BUF→0x0F.
  - NAND→0xFF, NOR→0x00, XNOR→0xC3.
  - Each result appears exactly 2 cycles after acceptance.
- Streaming: 6 consecutive OR beats, `out_ready`=1 → `in_ready` never drops. Six consecutive `out_valid` cycles, results in order.
- Backpressure: `out_ready`=0 for 5 cycles with output valid.
  - `out_y` stable and `in_ready`=0 throughout.
  - After release, no beat is lost or duplicated.
- Accumulate XOR packet of 3 beats:
  - Beat reductions 0x11, 0x22, 0x44 → single output 0x77 on the last beat, none earlier.
  - Same packet with op=XNOR → 0x88.
  - `in_op` changed to AND on beat 2 → still 0x77.
- Abort/reset:
  - 2-beat AND packet interrupted by an `acc`=0 OR beat → only the OR result is output.
  - `rst` asserted mid-packet → all outputs 0 next cycle; a following packet is unaffected by the discarded data.
